// File: rtl/rast_bbox.sv
// Rasteriser bounding-box stage: per-triangle screen-space box, snapped to the
// MSAA subsample grid, clamped to the screen, with off-screen culling.
module rast_bbox #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned RADIX  = 10,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]     tri_R10S,
  input  logic [COLORS-1:0][SIGFIG-1:0]              color_R10U,
  input  logic                                       validTri_R10H,
  input  logic [1:0][SIGFIG-1:0]                     screen_RnnnnS,
  input  logic [3:0]                                 subSample_RnnnnU,
  output logic                                       halt_RnnnnL,
  input  logic                                       next_halt_RnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]     tri_R13S,
  output logic [COLORS-1:0][SIGFIG-1:0]              color_R13U,
  output logic [1:0][1:0][SIGFIG-1:0]                box_R13S,
  output logic                                       validTri_R13H,
  output logic [31:0]                                cullCount
);

  localparam int unsigned GW = $clog2(SIGFIG);

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;
  typedef logic [1:0][1:0][SIGFIG-1:0]            box_t;

  logic             stall_c;
  logic [GW-1:0]    g_c;
  logic [SIGFIG-1:0] step_c;
  logic [SIGFIG-1:0] mask_c;
  logic [1:0][SIGFIG-1:0] lim_c;

  logic valid_r11_q, valid_r11_d, valid_r12_q, valid_r12_d, valid_r13_q, valid_r13_d;
  tri_t tri_r11_q, tri_r11_d, tri_r12_q, tri_r12_d, tri_r13_q, tri_r13_d;
  col_t col_r11_q, col_r11_d, col_r12_q, col_r12_d, col_r13_q, col_r13_d;
  box_t box_r11_q, box_r11_d, box_r12_q, box_r12_d, box_r13_q, box_r13_d;
  logic off_r12_q, off_r12_d;
  logic [31:0] cull_q, cull_d;

  assign stall_c     = ~next_halt_RnnnnL;
  assign halt_RnnnnL = next_halt_RnnnnL;

  // Grid LSB from the MSAA mode; anything not one-hot behaves as x1.
  always_comb begin
    g_c = GW'(RADIX);
    case (subSample_RnnnnU)
      4'b1000: g_c = GW'(RADIX);
      4'b0100: g_c = GW'(RADIX - 1);
      4'b0010: g_c = GW'(RADIX - 2);
      4'b0001: g_c = GW'(RADIX - 3);
      default: g_c = GW'(RADIX);
    endcase
  end

  assign step_c = SIGFIG'(1) << g_c;
  assign mask_c = ~(step_c - SIGFIG'(1));

  always_comb begin
    valid_r11_d = validTri_R10H;
    tri_r11_d   = tri_R10S;
    col_r11_d   = color_R10U;
    box_r11_d   = '0;
    valid_r12_d = valid_r11_q;
    tri_r12_d   = tri_r11_q;
    col_r12_d   = col_r11_q;
    box_r12_d   = '0;
    off_r12_d   = 1'b0;
    valid_r13_d = valid_r12_q & ~off_r12_q;
    tri_r13_d   = tri_r12_q;
    col_r13_d   = col_r12_q;
    box_r13_d   = '0;
    lim_c       = '0;
    cull_d      = cull_q;

    // R10->R11: signed min/max over vertices for x and y
    for (int unsigned a = 0; a < 2; a++) begin
      box_r11_d[0][a] = tri_R10S[0][a];
      box_r11_d[1][a] = tri_R10S[0][a];
      for (int unsigned v = 1; v < VERTS; v++) begin
        if ($signed(tri_R10S[v][a]) < $signed(box_r11_d[0][a])) box_r11_d[0][a] = tri_R10S[v][a];
        if ($signed(tri_R10S[v][a]) > $signed(box_r11_d[1][a])) box_r11_d[1][a] = tri_R10S[v][a];
      end
    end

    // R11->R12: snap down to the grid; off-screen test uses the unsnapped box
    for (int unsigned i = 0; i < 2; i++) begin
      for (int unsigned a = 0; a < 2; a++) begin
        box_r12_d[i][a] = box_r11_q[i][a] & mask_c;
      end
    end
    off_r12_d = box_r11_q[1][0][SIGFIG-1] | box_r11_q[1][1][SIGFIG-1]
              | ($signed(box_r11_q[0][0]) >= $signed(screen_RnnnnS[0]))
              | ($signed(box_r11_q[0][1]) >= $signed(screen_RnnnnS[1]));

    // R12->R13: clamp to [0, screen - one grid step]
    for (int unsigned a = 0; a < 2; a++) begin
      lim_c[a] = screen_RnnnnS[a] - step_c;
      box_r13_d[0][a] = box_r12_q[0][a][SIGFIG-1] ? '0 : box_r12_q[0][a];
      box_r13_d[1][a] = ($signed(box_r12_q[1][a]) > $signed(lim_c[a])) ? lim_c[a] : box_r12_q[1][a];
    end

    if (valid_r12_q && off_r12_q && (cull_q != 32'hFFFF_FFFF)) cull_d = cull_q + 32'd1;
  end

  // Whole pipe, bubbles included, freezes on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r11_q <= 1'b0;
      valid_r12_q <= 1'b0;
      valid_r13_q <= 1'b0;
      tri_r11_q   <= '0;
      tri_r12_q   <= '0;
      tri_r13_q   <= '0;
      col_r11_q   <= '0;
      col_r12_q   <= '0;
      col_r13_q   <= '0;
      box_r11_q   <= '0;
      box_r12_q   <= '0;
      box_r13_q   <= '0;
      off_r12_q   <= 1'b0;
      cull_q      <= '0;
    end else if (!stall_c) begin
      valid_r11_q <= valid_r11_d;
      valid_r12_q <= valid_r12_d;
      valid_r13_q <= valid_r13_d;
      tri_r11_q   <= tri_r11_d;
      tri_r12_q   <= tri_r12_d;
      tri_r13_q   <= tri_r13_d;
      col_r11_q   <= col_r11_d;
      col_r12_q   <= col_r12_d;
      col_r13_q   <= col_r13_d;
      box_r11_q   <= box_r11_d;
      box_r12_q   <= box_r12_d;
      box_r13_q   <= box_r13_d;
      off_r12_q   <= off_r12_d;
      cull_q      <= cull_d;
    end
  end

  assign tri_R13S      = tri_r13_q;
  assign color_R13U    = col_r13_q;
  assign box_R13S      = box_r13_q;
  assign validTri_R13H = valid_r13_q;
  assign cullCount     = cull_q;

endmodule

// File: doc/rast_bbox.md
# rast_bbox

Front-end pipeline stage of the rasteriser, directly downstream of the triangle source (bench driver or vertex front end). It accepts one triangle per cycle on the R10 interface, computes its screen-space bounding box snapped to the current subsample grid, clamps it to the screen, culls fully off-screen triangles, and presents the triangle plus box at R13 to the sample iterator. Back-pressure from the iterator stalls the whole pipe and is forwarded upstream.

## Interface
- SIGFIG, 24, bits in position/color words (signed fixed point)
- RADIX, 10, fraction bits
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels
- clk  in  1  clock; one clock domain, all state on rising edge
- rst  in  1  synchronous, active-high reset
- tri_R10S  in  VERTS x AXIS x SIGFIG signed  vertex coordinates
- color_R10U  in  COLORS x SIGFIG  triangle color
- validTri_R10H  in  1  input triangle valid
- screen_RnnnnS  in  2 x SIGFIG signed  screen width [0], height [1], quasi-static
- subSample_RnnnnU  in  4  one-hot MSAA: 1000=x1, 0100=x4, 0010=x16, 0001=x64
- halt_RnnnnL  out  1  to upstream; 1 = ready, 0 = hold inputs
- next_halt_RnnnnL  in  1  from downstream; 1 = downstream accepting
- tri_R13S  out  VERTS x AXIS x SIGFIG signed  triangle, delayed
- color_R13U  out  COLORS x SIGFIG  color, delayed
- box_R13S  out  2 x 2 x SIGFIG signed  [0]=ll {x,y}, [1]=ur {x,y}
- validTri_R13H  out  1  output triangle valid (culled triangles never assert)
- cullCount  out  32  saturating count of culled triangles

## Operation
- Three register stages R11, R12, R13; each holds valid, tri, color, and its stage-specific box data.
- Stall: stall = !next_halt_RnnnnL. While stalled, every stage register holds, including invalid bubbles; no bubble collapsing. halt_RnnnnL = next_halt_RnnnnL (combinational pass-through). Upstream must hold R10 inputs while halt_RnnnnL=0; the block samples R10 only on non-stalled edges.
- R10->R11: signed min/max of x and y over the VERTS vertices (z ignored).
- R11->R12: grid snap. Grid LSB g = RADIX for x1, RADIX-1 for x4, RADIX-2 for x16, RADIX-3 for x64; clear bits [g-1:0] of all four box values (floor toward -inf, two's complement). Also compute off = (ur_x<0)|(ur_y<0)|(ll_x>=screen_x)|(ll_y>=screen_y) from the unsnapped R11 values.
- R12->R13: clamp ll to >=0; clamp ur to <= screen - 2^g per axis. validTri_R13H = valid_R12 & !off.
- cullCount increments by 1 on each non-stalled edge where valid_R12 & off; holds at 0xFFFFFFFF.
- subSample_RnnnnU is not one-hot: treat as x1.
- Degenerate (zero-area) triangles are not culled here.

## Timing
- Latency: 3 non-stalled cycles R10->R13; throughput 1 triangle/cycle.
- Stall cycles add exactly one cycle of latency each; R13 outputs stay stable throughout a stall.
- Reset: all valid bits 0; all tri/color/box registers 0; cullCount 0. halt_RnnnnL follows next_halt_RnnnnL even in reset.
- Reset mid-operation: in-flight triangles are discarded; first valid output appears 3 cycles after the first non-stalled valid input following reset release.
- A stall asserted on the same edge as a valid input means that input is not captured.
- Screen/subsample changes only with the pipe empty; mid-flight changes give undefined boxes for in-flight triangles only.

## Test plan
- x4, screen 512x512, triangle (100.6,20.3),(300.8,40.0),(150.0,400.7), no stall -> 3 cycles later valid=1, box ll=(100.5,20.0), ur=(300.5,400.5) (raw 0x19200,0x05000 / 0x4B200,0x64200), tri/color bit-exact.
- x1, triangle (-10,-5),(700,20),(30,600) -> ll=(0,0), ur=(511,511) (0x7FC00); x64 same triangle -> ur=(511.875,511.875).
- Triangle (600,10),(700,20),(650,90) on 512 screen -> validTri_R13H stays 0, cullCount 0->1; back-to-back 5 such -> cullCount 5.
- Stream of 8 valid triangles with next_halt_RnnnnL low for 4 cycles mid-stream -> halt_RnnnnL low same cycles, all 8 emerge in order, none lost or duplicated, R13 stable during stall.
- rst asserted for 1 cycle with 3 triangles in flight -> all outputs 0 next cycle, no stale triangle emerges afterwards.
- cullCount preset near max (force 0xFFFFFFFE), 3 culls -> saturates at 0xFFFFFFFF.
